// File: rtl/wb_intercon_n.sv
// Single-master Wishbone interconnect: address-decodes one master onto N slaves,
// with a bus error for unmapped addresses and a per-transfer response timeout.
module wb_intercon_n #(
    parameter int                      data_width  = 32,
    parameter int                      num_slaves  = 4,
    parameter logic [num_slaves*32-1:0] slave_masks = '0,
    parameter logic [num_slaves*32-1:0] slave_addrs = '0,
    parameter int                      timeout     = 255
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [31:0]                      wbm_adr_i,
    input  logic [data_width-1:0]            wbm_dat_i,
    input  logic [data_width/8-1:0]          wbm_sel_i,
    input  logic                             wbm_we_i,
    input  logic                             wbm_cyc_i,
    input  logic                             wbm_stb_i,
    output logic [data_width-1:0]            wbm_dat_o,
    output logic                             wbm_ack_o,
    output logic                             wbm_err_o,
    output logic [31:0]                      wbs_adr_o,
    output logic [data_width-1:0]            wbs_dat_o,
    output logic [data_width/8-1:0]          wbs_sel_o,
    output logic                             wbs_we_o,
    output logic [num_slaves-1:0]            wbs_cyc_o,
    output logic [num_slaves-1:0]            wbs_stb_o,
    input  logic [num_slaves*data_width-1:0] wbs_dat_i,
    input  logic [num_slaves-1:0]            wbs_ack_i,
    input  logic [num_slaves-1:0]            wbs_err_i
);
    typedef enum logic [1:0] {IDLE, ACTIVE, ERR} state_t;

    localparam int          IW      = (num_slaves > 1) ? $clog2(num_slaves) : 1;
    localparam logic [15:0] TO_LAST = 16'(timeout - 1);

    state_t        state, state_n;
    logic [IW-1:0] cur, cur_n, sel;
    logic [15:0]   cnt, cnt_n;
    logic          hit, rsp_ack, rsp_err;

    assign wbs_adr_o = wbm_adr_i;
    assign wbs_dat_o = wbm_dat_i;
    assign wbs_sel_o = wbm_sel_i;
    assign wbs_we_o  = wbm_we_i;

    // Scan downward so the lowest matching index is the last one written.
    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int k = num_slaves - 1; k >= 0; k--) begin
            if ((wbm_adr_i & slave_masks[k*32 +: 32]) == slave_addrs[k*32 +: 32]) begin
                hit = 1'b1;
                sel = IW'(k);
            end
        end
    end

    assign rsp_ack = wbs_ack_i[cur] & wbm_cyc_i;
    assign rsp_err = wbs_err_i[cur] & wbm_cyc_i;

    always_comb begin
        state_n   = state;
        cur_n     = cur;
        cnt_n     = cnt;
        wbm_dat_o = '0;
        wbm_ack_o = 1'b0;
        wbm_err_o = 1'b0;
        wbs_cyc_o = '0;
        wbs_stb_o = '0;
        case (state)
            IDLE: begin
                if (wbm_cyc_i && wbm_stb_i) begin
                    if (hit) begin
                        cur_n   = sel;
                        cnt_n   = '0;
                        state_n = ACTIVE;
                    end else begin
                        state_n = ERR;
                    end
                end
            end
            ACTIVE: begin
                wbs_cyc_o[cur] = wbm_cyc_i;
                wbs_stb_o[cur] = wbm_stb_i;
                wbm_dat_o      = wbs_dat_i[int'(cur)*data_width +: data_width];
                // An err alongside an ack wins; the ack is suppressed.
                wbm_err_o      = rsp_err;
                wbm_ack_o      = rsp_ack & ~rsp_err;
                if (!wbm_cyc_i || rsp_ack || rsp_err) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (timeout != 0 && cnt == TO_LAST) begin
                    state_n = ERR;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            ERR: begin
                wbm_err_o = 1'b1;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            cur   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cur   <= cur_n;
            cnt   <= cnt_n;
        end
    end
endmodule

// File: tb/tb_wb_intercon_n.sv
// Scoreboarded bench for wb_intercon_n: expected master responses are queued when
// a transfer is set up and popped whenever the master sees ack or err.
module tb_wb_intercon_n;
    localparam int DW = 32;
    localparam int NS = 4;

    logic            clk_i = 1'b0, rst_i;
    logic [31:0]     wbm_adr_i;
    logic [DW-1:0]   wbm_dat_i;
    logic [DW/8-1:0] wbm_sel_i;
    logic            wbm_we_i, wbm_cyc_i, wbm_stb_i;
    logic [DW-1:0]   wbm_dat_o;
    logic            wbm_ack_o, wbm_err_o;
    logic [31:0]     wbs_adr_o;
    logic [DW-1:0]   wbs_dat_o;
    logic [DW/8-1:0] wbs_sel_o;
    logic            wbs_we_o;
    logic [NS-1:0]   wbs_cyc_o, wbs_stb_o;
    logic [NS*DW-1:0] wbs_dat_i;
    logic [NS-1:0]   wbs_ack_i, wbs_err_i;

    wb_intercon_n #(
        .data_width (DW),
        .num_slaves (NS),
        .slave_masks({4{32'hF000_0000}}),
        .slave_addrs({32'h2000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
        .timeout    (8)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
        .wbm_we_i(wbm_we_i), .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i),
        .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
        .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
        .wbs_we_o(wbs_we_o), .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o),
        .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  kind;  // 2'b10 ack, 2'b01 err
        logic [31:0] dat;
    } rsp_t;

    rsp_t sb[$];
    int   n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_rsp(input logic [1:0] kind, input logic [31:0] dat);
        rsp_t r;
        r.kind = kind;
        r.dat  = dat;
        sb.push_back(r);
    endtask

    // Mid-cycle sample: any ack/err must match the head of the scoreboard.
    task automatic half();
        rsp_t e;
        @(negedge clk_i);
        if (wbm_ack_o || wbm_err_o) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", {wbm_ack_o, wbm_err_o}, 2'b00);
            end else begin
                e = sb.pop_front();
                chk("rsp_kind", {wbm_ack_o, wbm_err_o}, e.kind);
                if (e.kind == 2'b10) chk("rsp_dat", wbm_dat_o, e.dat);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic cycle();
        half();
        tick();
    endtask

    task automatic req(input logic [31:0] adr, input logic we);
        wbm_adr_i = adr;
        wbm_we_i  = we;
        wbm_cyc_i = 1'b1;
        wbm_stb_i = 1'b1;
    endtask

    task automatic idle_master();
        wbm_cyc_i = 1'b0;
        wbm_stb_i = 1'b0;
        wbs_ack_i = '0;
        wbs_err_i = '0;
    endtask

    initial begin
        rst_i     = 1'b1;
        wbm_adr_i = '0; wbm_dat_i = 32'h5A5A_0001; wbm_sel_i = 4'hF; wbm_we_i = 1'b0;
        wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
        wbs_ack_i = '0; wbs_err_i = '0;
        for (int k = 0; k < NS; k++) wbs_dat_i[k*DW +: DW] = 32'h1111_1111 * (k + 1);
        tick(); tick();
        half();
        chk("rst_stb", wbs_stb_o, 4'b0000);
        chk("rst_cyc", wbs_cyc_o, 4'b0000);
        chk("rst_ackerr_dat", {wbm_ack_o, wbm_err_o, wbm_dat_o}, 34'd0);
        tick();
        rst_i = 1'b0;
        tick();

        // Read slave 1, ack two cycles after its strobe
        req(32'h1000_0004, 1'b0);
        half(); chk("rd_c0_stb", wbs_stb_o, 4'b0000);
        chk("bcast_adr", wbs_adr_o, 32'h1000_0004);
        tick();
        half(); chk("rd_c1_stb", wbs_stb_o, 4'b0010); tick();
        half(); chk("rd_c2_stb", wbs_stb_o, 4'b0010); tick();
        wbs_dat_i[1*DW +: DW] = 32'hCAFE_F00D;
        wbs_ack_i = 4'b0010;
        expect_rsp(2'b10, 32'hCAFE_F00D);
        cycle();
        idle_master();
        half(); chk("rd_after_stb", wbs_stb_o, 4'b0000); tick();

        // Overlapping slaves 2/3: lowest wins, spurious ack from 3 ignored
        req(32'h2000_0000, 1'b1);
        cycle();
        wbs_ack_i = 4'b1000;
        half(); chk("ovl_stb", wbs_stb_o, 4'b0100); chk("ovl_cyc", wbs_cyc_o, 4'b0100);
        chk("ovl_we", wbs_we_o, 1'b1);
        tick();
        wbs_ack_i = 4'b0100;
        expect_rsp(2'b10, 32'h3333_3333);
        cycle();
        idle_master();
        cycle();

        // Unmapped address: one-cycle err on cycle 1, no strobes
        req(32'h4000_0000, 1'b0);
        half(); chk("unm_c0_stb", wbs_stb_o, 4'b0000); tick();
        expect_rsp(2'b01, 32'h0);
        half(); chk("unm_c1_stb", wbs_stb_o, 4'b0000); chk("unm_c1_dat", wbm_dat_o, 32'h0);
        tick();
        idle_master();
        half(); chk("unm_c2_err", wbm_err_o, 1'b0); tick();

        // Timeout on slave 0: 8 ACTIVE cycles then ERR
        req(32'h0000_0010, 1'b0);
        cycle();
        for (int i = 0; i < 8; i++) begin
            half(); chk($sformatf("to_act%0d_stb", i), wbs_stb_o, 4'b0001); tick();
        end
        expect_rsp(2'b01, 32'h0);
        half(); chk("to_err_stb", wbs_stb_o, 4'b0000); chk("to_err_ack", wbm_ack_o, 1'b0);
        tick();
        idle_master();
        cycle();
        // Following access completes normally
        req(32'h0000_0020, 1'b0);
        cycle();
        wbs_dat_i[0 +: DW] = 32'h1234_5678;
        wbs_ack_i = 4'b0001;
        expect_rsp(2'b10, 32'h1234_5678);
        half(); chk("after_to_stb", wbs_stb_o, 4'b0001); tick();
        idle_master();
        cycle();

        // Master drops cyc on ACTIVE cycle 3; late ack ignored
        req(32'h1000_0000, 1'b0);
        cycle(); cycle(); cycle();
        wbm_cyc_i = 1'b0;
        half(); chk("abort_cyc", wbs_cyc_o, 4'b0000); tick();
        wbm_stb_i = 1'b0;
        wbs_ack_i = 4'b0010;
        half(); chk("abort_idle", {wbs_cyc_o, wbs_stb_o, wbm_dat_o}, 40'd0); tick();
        idle_master();
        cycle();

        // Reset on ACTIVE cycle 2; late ack ignored
        req(32'h1000_0000, 1'b0);
        cycle(); cycle();
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
        idle_master();
        wbs_ack_i = 4'b0010;
        wbm_cyc_i = 1'b1;  // cyc alone without stb must not restart or leak the ack
        half(); chk("rst_mid_idle", {wbs_cyc_o, wbs_stb_o, wbm_ack_o, wbm_err_o}, 10'd0); tick();
        idle_master();
        cycle();

        // Simultaneous ack and err from slave 1 -> err only
        req(32'h1000_0008, 1'b0);
        cycle();
        wbs_ack_i = 4'b0010;
        wbs_err_i = 4'b0010;
        expect_rsp(2'b01, 32'h0);
        cycle();
        idle_master();
        cycle(); cycle();

        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/wb_intercon_n.md
WB_INTERCON_N -- requirements
Module: wb_intercon_n

Interface
REQ-001 SHALL provide parameter data_width, default 32, meaning data bus width in bits; legal values are multiples of 8.
REQ-002 SHALL provide parameter num_slaves, default 4, meaning slave port count; legal range is 1..16.
REQ-003 SHALL provide parameter slave_masks, default all zero, meaning num_slaves*32-bit vector with slave k mask at [k*32 +: 32].
REQ-004 SHALL provide parameter slave_addrs, default all zero, meaning num_slaves*32-bit vector with slave k base at [k*32 +: 32].
REQ-005 SHALL provide parameter timeout, default 255, meaning the limit of cycles without a response before bus error; 0 disables the timeout; legal range is 0..65535.
REQ-006 SHALL have one clock and a synchronous, active-high reset, with ports named clk_i and rst_i as elsewhere in the codebase.
REQ-007 clk_i  input  1  clock; all state SHALL change on its rising edge.
REQ-008 rst_i  input  1  synchronous, active-high reset.
REQ-009 wbm_adr_i  input  32  master address.
REQ-010 wbm_dat_i  input  data_width  master write data.
REQ-011 wbm_sel_i  input  data_width/8  master byte selects.
REQ-012 wbm_we_i, wbm_cyc_i, wbm_stb_i  input  1 each  master write enable, cycle and strobe.
REQ-013 wbm_dat_o  output  data_width  read data returned to the master.
REQ-014 wbm_ack_o, wbm_err_o  output  1 each  master acknowledge and bus error.
REQ-015 wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o  output  32/data_width/data_width/8/1  shared broadcast of the master inputs.
REQ-016 wbs_cyc_o, wbs_stb_o  output  num_slaves each  per-slave cycle and strobe, one bit per slave.
REQ-017 wbs_dat_i  input  num_slaves*data_width  slave k read data at [k*data_width +: data_width].
REQ-018 wbs_ack_i, wbs_err_i  input  num_slaves each  per-slave acknowledge and error.

Function
REQ-019 wbs_adr_o, wbs_dat_o, wbs_sel_o and wbs_we_o SHALL be combinational copies of the corresponding wbm inputs.
REQ-020 Slave k SHALL match when (wbm_adr_i & mask_k) == addr_k; the lowest-index matching slave SHALL win.
REQ-021 The FSM SHALL have three states: IDLE, ACTIVE and ERR.
REQ-022 In IDLE with wbm_cyc_i&wbm_stb_i=1 and a matching slave, the block SHALL register the winning index into cur and go to ACTIVE.
REQ-023 In IDLE with wbm_cyc_i&wbm_stb_i=1 and no matching slave, the block SHALL go to ERR.
REQ-024 In ACTIVE, the block SHALL drive wbs_cyc_o[cur]=wbm_cyc_i and wbs_stb_o[cur]=wbm_stb_i, and every other wbs_cyc_o/wbs_stb_o bit SHALL be 0; slave strobes therefore appear 1 cycle after the master strobe.
REQ-025 In ACTIVE, wbm_ack_o SHALL equal wbs_ack_i[cur]&wbm_cyc_i combinationally, wbm_err_o SHALL equal wbs_err_i[cur]&wbm_cyc_i, and wbm_dat_o SHALL equal slave cur data.
REQ-026 On an ACTIVE cycle with ack or err from slave cur, the block SHALL return to IDLE at the next edge; back-to-back transfers therefore have at least 1 IDLE cycle between them.
REQ-027 In ACTIVE, ack and err from any slave other than cur SHALL be ignored.
REQ-028 Simultaneous wbs_ack_i[cur] and wbs_err_i[cur] SHALL be forwarded as err only, with wbm_ack_o=0.
REQ-029 Counter cnt (16 bits) SHALL clear on entering ACTIVE and increment each ACTIVE cycle with no response.
REQ-030 When timeout≠0 and cnt==timeout-1 with no response, the block SHALL go to ERR and drop all slave strobes at the next edge.
REQ-031 ERR SHALL last exactly 1 cycle with wbm_err_o=1 and wbm_ack_o=0, all wbs_cyc_o/wbs_stb_o=0 and wbm_dat_o=0, then go to IDLE.
REQ-032 If wbm_cyc_i falls in ACTIVE, the block SHALL abort to IDLE at the next edge with no ack/err issued and cnt cleared.
REQ-033 Outside ACTIVE and ERR, wbm_ack_o=0, wbm_err_o=0, wbm_dat_o=0, and all slave strobes SHALL be 0.

Reset
REQ-034 On rst_i=1 at a clock edge: state=IDLE, cur=0, cnt=0; thus wbm_ack_o=0, wbm_err_o=0, wbm_dat_o=0, wbs_cyc_o=0, wbs_stb_o=0.
REQ-035 Reset asserted mid-transaction SHALL take priority over all transitions; no ack/err SHALL be issued for the aborted transfer.

Verification
(num_slaves=4; masks 0xF0000000 each; addrs 0x00000000/0x10000000/0x20000000/0x20000000; timeout=8)
REQ-036 Read 0x10000004, slave 1 acks 2 cycles after its stb with data 0xCAFEF00D -> wbs_stb_o=4'b0010 from cycle 1, wbm_ack_o and wbm_dat_o=0xCAFEF00D in the same cycle as the slave ack.
REQ-037 Write 0x20000000 (overlapping slaves 2 and 3) -> only wbs_stb_o[2]=1; a spurious wbs_ack_i[3]=1 produces no wbm_ack_o.
REQ-038 Access 0x40000000 -> no slave strobe; wbm_err_o=1 for exactly 1 cycle, on cycle 1.
REQ-039 Access slave 0 with no ack -> after 8 ACTIVE cycles, wbs_stb_o drops to 0 and wbm_err_o pulses for 1 cycle; the next access proceeds normally.
REQ-040 Drop wbm_cyc_i at ACTIVE cycle 3, and separately assert rst_i at ACTIVE cycle 2 -> return to IDLE with all outputs 0 and no ack/err; a late slave ack is ignored.
REQ-041 Slave 1 asserts ack and err in the same cycle -> wbm_err_o=1, wbm_ack_o=0.
